// File: rtl/dataarray_wb_pkg.sv
// dataarray_wb_pkg: shared constants, request type and rotating find-first helper for the DataArray writeback writer
package dataarray_wb_pkg;
  localparam int NUM_WPORT = 2;
  localparam int WB_ADDR_W = 16;
  localparam int WB_DATA_W = 64;
  localparam int MAX_SRC = 32;
  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;
  // Returns {found, index} of the first set bit of req scanning from ptr, wrapping modulo n.
  function automatic logic [5:0] rr_find_first(input logic [MAX_SRC-1:0] req, input logic [4:0] ptr,
                                               input logic [5:0] n);
    rr_find_first = '0;
    for (int k = 0; k < MAX_SRC; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= int'(n)) idx -= int'(n);
      if (k < int'(n) && !rr_find_first[5] && idx < MAX_SRC && req[idx[4:0]])
        rr_find_first = {1'b1, idx[4:0]};
    end
  endfunction
endpackage

// File: rtl/data_array_wb_writer_rr_dual_picker.sv
// rr_dual_picker: picks up to two valid holds per cycle in rotating order, never two with the same address
module rr_dual_picker
  import dataarray_wb_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int NUM_ENTRIES = 16,
  parameter int SEL_W = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0]                          hv,
  input  logic [NUM_SRC-1:0][NUM_ENTRIES-1:0]         ha,
  input  logic [SEL_W-1:0]                            rr_ptr,
  output logic [NUM_WPORT-1:0][NUM_SRC-1:0]           gnt,
  output logic [NUM_WPORT-1:0]                        act,
  output logic [NUM_WPORT-1:0][SEL_W-1:0]             sel
);
  logic [MAX_SRC-1:0] req0, req1;
  logic [5:0] f0, f1;
  always_comb begin
    req0 = MAX_SRC'(hv);
    f0 = rr_find_first(req0, 5'(rr_ptr), 6'(NUM_SRC));
    sel[0] = SEL_W'(f0[4:0]);
    req1 = '0;
    for (int i = 0; i < NUM_SRC; i++)
      req1[i] = hv[i] && i != int'(f0[4:0]) && ha[i] != ha[sel[0]];
    f1 = rr_find_first(req1, 5'(rr_ptr), 6'(NUM_SRC));
    sel[1] = SEL_W'(f1[4:0]);
    act = {f1[5], f0[5]};
    gnt[0] = act[0] ? NUM_SRC'(1) << sel[0] : '0;
    gnt[1] = act[1] ? NUM_SRC'(1) << sel[1] : '0;
  end
endmodule

// File: rtl/data_array_wb_writer.sv
// data_array_wb_writer: buffers one writeback per source and issues up to two per cycle to the DataArray write ports
module data_array_wb_writer
  import dataarray_wb_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int NUM_ENTRIES = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                io_flush,
  input  logic [NUM_SRC-1:0]                  io_in_valid,
  output logic [NUM_SRC-1:0]                  io_in_ready,
  input  logic [NUM_SRC-1:0][NUM_ENTRIES-1:0] io_in_addr,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]      io_in_data,
  output logic                                io_delayedWrite_0_mask_0,
  output logic [NUM_ENTRIES-1:0]              io_delayedWrite_0_addr,
  output logic [DATA_W-1:0]                   io_delayedWrite_0_data_0,
  output logic                                io_delayedWrite_1_mask_0,
  output logic [NUM_ENTRIES-1:0]              io_delayedWrite_1_addr,
  output logic [DATA_W-1:0]                   io_delayedWrite_1_data_0,
  output logic [7:0]                          io_dropCount
);
  localparam int SEL_W = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  logic [NUM_SRC-1:0] hv, fire;
  logic [NUM_SRC-1:0][NUM_ENTRIES-1:0] ha;
  logic [NUM_SRC-1:0][DATA_W-1:0] hd;
  logic [SEL_W-1:0] rr_ptr, last, rr_next;
  logic [NUM_WPORT-1:0][NUM_SRC-1:0] gnt;
  logic [NUM_WPORT-1:0] act, mask;
  logic [NUM_WPORT-1:0][SEL_W-1:0] sel;
  logic [NUM_WPORT-1:0][NUM_ENTRIES-1:0] oaddr;
  logic [NUM_WPORT-1:0][DATA_W-1:0] odata;
  logic [15:0] drop_sum;
  logic [7:0] cnt_next;
  rr_dual_picker #(.NUM_SRC(NUM_SRC), .NUM_ENTRIES(NUM_ENTRIES), .SEL_W(SEL_W)) picker (
    .hv(hv), .ha(ha), .rr_ptr(rr_ptr), .gnt(gnt), .act(act), .sel(sel)
  );
  // Ready includes this cycle's grant so a winning source can stream back-to-back.
  always_comb begin
    io_in_ready = (reset || io_flush) ? '0 : ~hv | gnt[0] | gnt[1];
    fire = io_in_valid & io_in_ready;
    drop_sum = {8'd0, io_dropCount};
    for (int i = 0; i < NUM_SRC; i++)
      drop_sum += 16'(fire[i] && io_in_addr[i] == '0);
    cnt_next = drop_sum > 16'd255 ? 8'hFF : drop_sum[7:0];
    last = act[1] ? sel[1] : sel[0];
    rr_next = last == SEL_W'(NUM_SRC - 1) ? '0 : last + SEL_W'(1);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      hv <= '0;
      mask <= '0;
      oaddr <= '0;
      odata <= '0;
      rr_ptr <= '0;
      io_dropCount <= '0;
    end else if (io_flush) begin
      hv <= '0;
      mask <= '0;
    end else begin
      for (int k = 0; k < NUM_WPORT; k++) begin
        mask[k] <= act[k];
        if (act[k]) begin
          oaddr[k] <= ha[sel[k]];
          odata[k] <= hd[sel[k]];
        end
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (fire[i]) begin
          hv[i] <= |io_in_addr[i];
          ha[i] <= io_in_addr[i];
          hd[i] <= io_in_data[i];
        end else if (gnt[0][i] || gnt[1][i]) begin
          hv[i] <= 1'b0;
        end
      end
      if (|act) rr_ptr <= rr_next;
      io_dropCount <= cnt_next;
    end
  end
  assign io_delayedWrite_0_mask_0 = mask[0];
  assign io_delayedWrite_0_addr   = oaddr[0];
  assign io_delayedWrite_0_data_0 = odata[0];
  assign io_delayedWrite_1_mask_0 = mask[1];
  assign io_delayedWrite_1_addr   = oaddr[1];
  assign io_delayedWrite_1_data_0 = odata[1];
endmodule
